dtl_slave_ram: RTL and testbench
================================

# dtl_slave_ram

DTL slave (target) that terminates the DTL protocol into an on-chip single-port word memory. It is the responder end of the DTL chain: address isolators and interconnect sit upstream, and this block completes command, write-data and read-data handshakes, including block (burst) transfers. It serves as the standard local data/instruction memory behind an address-range filter. The filter has already rebased the address to zero.

## Interface
Parameters:
- INTERFACE_WIDTH, 32: data width in bits, a multiple of 8.
- INTERFACE_ADDR_WIDTH, 32: byte address width.
- INTERFACE_BLOCK_WIDTH, 5: width of BlockSize. A transfer has BlockSize+1 beats.
- MEM_DEPTH_LOG2, 10: log2 of the number of memory words.
- INTERFACE_NUM_ENABLES, INTERFACE_WIDTH/8: number of byte enables.

Ports:
- iClk, in, 1: the single clock; all state changes on its rising edge.
- iReset, in, 1: asynchronous, active-high reset.
- iDTL_IN_CommandValid, in, 1: command request.
- oDTL_IN_CommandAccept, out, 1: command accepted.
- iDTL_IN_Address, in, INTERFACE_ADDR_WIDTH: byte address of the first beat.
- iDTL_IN_CommandReadWrite, in, 1: 1 = write, 0 = read.
- iDTL_IN_BlockSize, in, INTERFACE_BLOCK_WIDTH: number of beats minus 1.
- iDTL_IN_WriteValid, in, 1: write beat valid.
- iDTL_IN_WriteLast, in, 1: marks the final write beat.
- oDTL_IN_WriteAccept, out, 1: write beat accepted.
- iDTL_IN_WriteEnable, in, INTERFACE_NUM_ENABLES: byte enables.
- iDTL_IN_WriteData, in, INTERFACE_WIDTH: write data.
- oDTL_IN_ReadValid, out, 1: read beat valid.
- oDTL_IN_ReadLast, out, 1: marks the final read beat.
- iDTL_IN_ReadAccept, in, 1: read beat accepted.
- oDTL_IN_ReadData, out, INTERFACE_WIDTH: read data.
- oProtocolError, out, 1: sticky flag, set when WriteLast disagrees with the beat count.

## Operation
- Word index = Address >> log2(INTERFACE_NUM_ENABLES), truncated to MEM_DEPTH_LOG2 bits. Upper address bits are ignored (the memory aliases), and byte-offset bits are ignored.
- A handshake is a cycle where valid and accept are both 1.
- Within a burst the word index increments by 1 per beat and wraps modulo 2^MEM_DEPTH_LOG2.
- States:
  - IDLE: CommandAccept=1. On a command handshake, latch the word index, latch BlockSize into a beat limit, clear the beat counter, and go to WRITE (ReadWrite=1) or RD_FETCH (ReadWrite=0).
  - WRITE: WriteAccept=1. On each write handshake, write the enabled bytes at the current index, then increment the index and beat counter. The handshake with counter == limit returns to IDLE.
  - RD_FETCH: memory read issued at the current index. The next state is always RD_VALID.
  - RD_VALID: ReadValid=1 with the registered data; ReadLast=1 when counter == limit. Data and ReadLast hold stable until ReadAccept. On accept: if last, go to IDLE; otherwise increment index and counter and go to RD_FETCH.
- Burst termination is governed by BlockSize only.
- WriteLast=1 on a non-final beat, or WriteLast=0 on the final beat, sets oProtocolError. The beat is still written and the counting continues as normal.
- oProtocolError clears only on reset.
- Only one command is outstanding at a time; CommandAccept=0 in every state except IDLE.
- Memory contents are not reset.

## Timing
- While iReset=1: state=IDLE and all outputs 0, including CommandAccept, ReadData and oProtocolError. CommandAccept becomes 1 once iReset is deasserted.
- Reset mid-burst aborts the transfer immediately. No further ReadValid or WriteAccept is produced. Memory writes already completed are retained.
- Write: command handshake at cycle T, WriteAccept=1 from T+1. A burst of N beats with continuous WriteValid completes at T+N, and CommandAccept=1 again at T+N+1.
- Read: command handshake at T, then RD_FETCH at T+1 and ReadValid=1 at T+2.
  - Accept at cycle A on a non-last beat gives the next ReadValid at A+2. Sustained throughput is 1 beat per 2 cycles.
  - Accept on the last beat at A gives CommandAccept=1 at A+1.
- Memory write is registered at the handshake edge. A read of the same word issued in a later command returns the new data.
- A write beat whose WriteEnable is all-zero completes the handshake but leaves memory unchanged.

## Test plan
- Reset check: assert iReset mid-cycle. Required: all outputs 0 asynchronously; after release, CommandAccept=1 on the next cycle with state IDLE.
- Single write then read: write 0xDEADBEEF at address 0x10 with BlockSize=0 and WriteEnable=0xF, then read 0x10. Required: ReadData=0xDEADBEEF, ReadLast=1, and ReadValid 2 cycles after the read command handshake.
- Byte enables: write 0x11223344 to address 0x20, then write 0xAABBCCDD with WriteEnable=0x5. Required: a read of 0x20 returns 0x11BB33DD.
- Burst with wrap: MEM_DEPTH_LOG2=10, write BlockSize=3 at word 1022. Required: words 1022, 1023, 0, 1 are written. A read burst from the same address returns the 4 values in order with ReadLast only on beat 4.
- Read backpressure: hold ReadAccept=0 for 5 cycles on beat 2 of a 4-beat read. Required: ReadValid, ReadData and ReadLast stable throughout; no beat skipped or duplicated.
- Protocol error: 2-beat write with WriteLast=1 on beat 1. Required: oProtocolError=1 sticky, both beats written, return to IDLE after beat 2; a new command is accepted normally.

Source files
------------

// File: rtl/dtl_slave_ram.sv
// DTL target that terminates command, write-data and read-data handshakes
// into a single-port word memory. One command is outstanding at a time; block
// transfers walk the word index upward and wrap at the top of the memory.
// Handshakes: a beat transfers on a rising edge where valid and accept are
// both 1. The initiator holds valid and payload until accepted; this block
// holds ReadValid, ReadData and ReadLast stable until ReadAccept.
module dtl_slave_ram #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int MEM_DEPTH_LOG2        = 10,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iDTL_IN_CommandValid,
    output logic                             oDTL_IN_CommandAccept,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_IN_Address,
    input  logic                             iDTL_IN_CommandReadWrite,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_IN_BlockSize,
    input  logic                             iDTL_IN_WriteValid,
    input  logic                             iDTL_IN_WriteLast,
    output logic                             oDTL_IN_WriteAccept,
    input  logic [INTERFACE_NUM_ENABLES-1:0] iDTL_IN_WriteEnable,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_IN_WriteData,
    output logic                             oDTL_IN_ReadValid,
    output logic                             oDTL_IN_ReadLast,
    input  logic                             iDTL_IN_ReadAccept,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_IN_ReadData,
    output logic                             oProtocolError,
    output logic [1:0]                       oDebugState
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_RD_FETCH = 2'd2,
        S_RD_VALID = 2'd3
    } state_t;

    localparam int OFFS  = $clog2(INTERFACE_NUM_ENABLES);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    logic [INTERFACE_WIDTH-1:0] mem [DEPTH];

    state_t                         state_q, state_d;
    logic [MEM_DEPTH_LOG2-1:0]      idx_q, idx_d;
    logic [INTERFACE_BLOCK_WIDTH-1:0] cnt_q, cnt_d;
    logic [INTERFACE_BLOCK_WIDTH-1:0] lim_q, lim_d;
    logic                           err_q, err_d;
    logic [INTERFACE_WIDTH-1:0]     rd_data_q, rd_data_d;

    logic [INTERFACE_ADDR_WIDTH-1:0] addr_shift;
    logic [MEM_DEPTH_LOG2-1:0]       cmd_idx;
    logic                            unused_addr_bits;
    logic                            cmd_accept;
    logic                            last_beat;
    logic                            mem_we;

    // Byte offset and upper address bits are dropped: the memory aliases.
    assign addr_shift       = iDTL_IN_Address >> OFFS;
    assign cmd_idx          = addr_shift[MEM_DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^addr_shift;

    // CommandAccept is gated by reset so every output is 0 while reset is held.
    assign cmd_accept = (state_q == S_IDLE) && !iReset;
    assign last_beat  = (cnt_q == lim_q);

    assign oDTL_IN_CommandAccept = cmd_accept;
    assign oDTL_IN_WriteAccept   = (state_q == S_WRITE);
    assign oDTL_IN_ReadValid     = (state_q == S_RD_VALID);
    assign oDTL_IN_ReadLast      = (state_q == S_RD_VALID) && last_beat;
    assign oDTL_IN_ReadData      = rd_data_q;
    assign oProtocolError        = err_q;
    assign oDebugState           = state_q;

    // Next-state, burst bookkeeping, protocol checking and read fetch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iDTL_IN_CommandValid && cmd_accept) begin
                    idx_d   = cmd_idx;
                    lim_d   = iDTL_IN_BlockSize;
                    cnt_d   = '0;
                    state_d = iDTL_IN_CommandReadWrite ? S_WRITE : S_RD_FETCH;
                end
            end
            S_WRITE: begin
                if (iDTL_IN_WriteValid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + {{(MEM_DEPTH_LOG2-1){1'b0}}, 1'b1};
                    cnt_d  = cnt_q + {{(INTERFACE_BLOCK_WIDTH-1){1'b0}}, 1'b1};
                    // WriteLast is only checked; BlockSize alone ends the burst.
                    if (iDTL_IN_WriteLast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_FETCH: begin
                rd_data_d = mem[idx_q];
                state_d   = S_RD_VALID;
            end
            S_RD_VALID: begin
                if (iDTL_IN_ReadAccept) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + {{(MEM_DEPTH_LOG2-1){1'b0}}, 1'b1};
                        cnt_d   = cnt_q + {{(INTERFACE_BLOCK_WIDTH-1){1'b0}}, 1'b1};
                        state_d = S_RD_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and read-data registers; reset aborts any transfer at once.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            lim_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge iClk) begin
        if (mem_we) begin
            for (int i = 0; i < INTERFACE_NUM_ENABLES; i++) begin
                if (iDTL_IN_WriteEnable[i]) begin
                    mem[idx_q][i*8 +: 8] <= iDTL_IN_WriteData[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dtl_slave_ram.sv
// Bench for dtl_slave_ram: driver tasks for DTL write/read transactions, a
// word-array reference memory, and one task per scenario with inline checks.
module tb_dtl_slave_ram;

  localparam int W = 32;
  localparam int DEPTH = 1024;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_accept;
  logic [31:0] cmd_addr = '0;
  logic        cmd_rw = 1'b0;
  logic [4:0]  cmd_bs = '0;
  logic        w_valid = 1'b0;
  logic        w_last = 1'b0;
  logic        w_accept;
  logic [3:0]  w_en = '0;
  logic [31:0] w_data = '0;
  logic        r_valid;
  logic        r_last;
  logic        r_accept = 1'b0;
  logic [31:0] r_data;
  logic        prot_err;
  logic [1:0]  dbg_state;

  dtl_slave_ram dut (
    .iClk(clk), .iReset(rst),
    .iDTL_IN_CommandValid(cmd_valid), .oDTL_IN_CommandAccept(cmd_accept),
    .iDTL_IN_Address(cmd_addr), .iDTL_IN_CommandReadWrite(cmd_rw),
    .iDTL_IN_BlockSize(cmd_bs),
    .iDTL_IN_WriteValid(w_valid), .iDTL_IN_WriteLast(w_last),
    .oDTL_IN_WriteAccept(w_accept), .iDTL_IN_WriteEnable(w_en),
    .iDTL_IN_WriteData(w_data),
    .oDTL_IN_ReadValid(r_valid), .oDTL_IN_ReadLast(r_last),
    .iDTL_IN_ReadAccept(r_accept), .oDTL_IN_ReadData(r_data),
    .oProtocolError(prot_err), .oDebugState(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // reference memory: word contents plus which words hold known data
  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];

  // per-transaction stimulus and observations
  logic [31:0] wd [32];
  logic [3:0]  we [32];
  bit          wl [32];
  logic [31:0] rd_data_q[$];
  bit          rd_last_q[$];
  int          rd_lat_q[$];
  logic [W-1:0] exp_q[$];
  bit          drv_timeout = 0;
  bit          wa_missing = 0;
  bit          rd_stable_err = 0;
  logic        cmd_acc_after;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[idx][k*8 +: 8] = d[k*8 +: 8];
    if (be == 4'hF) ref_known[idx] = 1;
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge)
  task automatic wait_idle();
    int n;
    n = 0;
    while (cmd_accept !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_accept !== 1'b1) drv_timeout = 1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int bs);
    int idx;
    idx = idx_of(addr);
    wa_missing = 0;
    wait_idle();
    cmd_valid = 1; cmd_addr = addr; cmd_rw = 1; cmd_bs = 5'(bs);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int b = 0; b <= bs; b++) begin
      w_valid = 1; w_data = wd[b]; w_en = we[b]; w_last = wl[b];
      if (w_accept !== 1'b1 || cmd_accept !== 1'b0) wa_missing = 1;
      @(posedge clk);
      model_write((idx + b) % DEPTH, wd[b], we[b]);
      @(negedge clk);
    end
    w_valid = 0; w_last = 0; w_en = '0;
    cmd_acc_after = cmd_accept;
  endtask

  task automatic do_read(input logic [31:0] addr, input int bs, input int stall_beat, input int stall_n);
    int lat;
    logic [31:0] d0;
    logic l0;
    rd_data_q.delete(); rd_last_q.delete(); rd_lat_q.delete();
    rd_stable_err = 0;
    wait_idle();
    cmd_valid = 1; cmd_addr = addr; cmd_rw = 0; cmd_bs = 5'(bs);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int b = 0; b <= bs; b++) begin
      lat = 1;
      while (r_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (r_valid !== 1'b1) begin
        drv_timeout = 1;
        return;
      end
      d0 = r_data; l0 = r_last;
      if (b == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          if (r_valid !== 1'b1 || r_data !== d0 || r_last !== l0) rd_stable_err = 1;
        end
      end
      rd_lat_q.push_back(lat); rd_data_q.push_back(d0); rd_last_q.push_back(l0);
      r_accept = 1;
      @(posedge clk);
      @(negedge clk);
      r_accept = 0;
    end
    cmd_acc_after = cmd_accept;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    #3 rst = 1;
    #1;
    total++;
    if ({cmd_accept, w_accept, r_valid, r_last, r_data, prot_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {cmd_accept, w_accept, r_valid, r_last, r_data, prot_err});
    end
    total++;
    if (dbg_state !== IDLE_CODE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE_CODE); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++;
    if (cmd_accept !== 1'b1) begin bad++; $display("FAIL reset_release_accept: got %b want 1", cmd_accept); end
    total++;
    if (dbg_state !== IDLE_CODE) begin bad++; $display("FAIL reset_release_state: got %0d want %0d", dbg_state, IDLE_CODE); end
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; we[0] = 4'hF; wl[0] = 1;
    do_write(32'h10, 0);
    total++;
    if (wa_missing !== 0) begin bad++; $display("FAIL single_write_accept: got %b want 0", wa_missing); end
    total++;
    if (cmd_acc_after !== 1'b1) begin bad++; $display("FAIL single_write_idle: got %b want 1", cmd_acc_after); end
    do_read(32'h10, 0, -1, 0);
    total++;
    if (rd_data_q.size() !== 1) begin bad++; $display("FAIL single_read_count: got %0d want 1", rd_data_q.size()); end
    else begin
      total++;
      if (rd_data_q[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_read_data: got %h want deadbeef", rd_data_q[0]); end
      total++;
      if (rd_last_q[0] !== 1) begin bad++; $display("FAIL single_read_last: got %b want 1", rd_last_q[0]); end
      total++;
      if (rd_lat_q[0] !== 2) begin bad++; $display("FAIL single_read_latency: got %0d want 2", rd_lat_q[0]); end
    end
    total++;
    if (cmd_acc_after !== 1'b1) begin bad++; $display("FAIL single_read_idle: got %b want 1", cmd_acc_after); end
  endtask

  task automatic test_byte_enables();
    wd[0] = 32'h11223344; we[0] = 4'hF; wl[0] = 1;
    do_write(32'h20, 0);
    wd[0] = 32'hAABBCCDD; we[0] = 4'h5; wl[0] = 1;
    do_write(32'h20, 0);
    do_read(32'h20, 0, -1, 0);
    total++;
    if (rd_data_q.size() !== 1 || rd_data_q[0] !== 32'h11BB33DD) begin
      bad++; $display("FAIL byte_enable_data: got %h want 11bb33dd", rd_data_q.size() > 0 ? rd_data_q[0] : 32'hx);
    end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] vals [4];
    for (int b = 0; b < 4; b++) begin
      vals[b] = $urandom(); wd[b] = vals[b]; we[b] = 4'hF; wl[b] = (b == 3);
    end
    do_write(32'h0000_0FF8, 3);
    total++;
    if (prot_err !== 1'b0) begin bad++; $display("FAIL wrap_no_error: got %b want 0", prot_err); end
    // aliased address: upper bits and byte offset differ, word index is 1022
    do_read(32'hABC0_0FFB, 3, -1, 0);
    total++;
    if (rd_data_q.size() !== 4) begin bad++; $display("FAIL wrap_read_count: got %0d want 4", rd_data_q.size()); end
    else begin
      for (int b = 0; b < 4; b++) begin
        total++;
        if (rd_data_q[b] !== vals[b]) begin bad++; $display("FAIL wrap_data beat%0d: got %h want %h", b, rd_data_q[b], vals[b]); end
        total++;
        if (rd_last_q[b] !== (b == 3)) begin bad++; $display("FAIL wrap_last beat%0d: got %b want %b", b, rd_last_q[b], b == 3); end
        total++;
        if (rd_lat_q[b] !== 2) begin bad++; $display("FAIL wrap_latency beat%0d: got %0d want 2", b, rd_lat_q[b]); end
      end
    end
    do_read(32'h0, 0, -1, 0);
    total++;
    if (rd_data_q.size() !== 1 || rd_data_q[0] !== vals[2]) begin bad++; $display("FAIL wrap_word0: got %h want %h", rd_data_q.size() > 0 ? rd_data_q[0] : 32'hx, vals[2]); end
    do_read(32'h4, 0, -1, 0);
    total++;
    if (rd_data_q.size() !== 1 || rd_data_q[0] !== vals[3]) begin bad++; $display("FAIL wrap_word1: got %h want %h", rd_data_q.size() > 0 ? rd_data_q[0] : 32'hx, vals[3]); end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 4; b++) begin
      wd[b] = $urandom(); we[b] = 4'hF; wl[b] = (b == 3);
    end
    do_write(32'h400, 3);
    do_read(32'h400, 3, 1, 5);
    total++;
    if (rd_stable_err !== 0) begin bad++; $display("FAIL bp_stable: got %b want 0", rd_stable_err); end
    total++;
    if (rd_data_q.size() !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", rd_data_q.size()); end
    else begin
      for (int b = 0; b < 4; b++) begin
        total++;
        if (rd_data_q[b] !== ref_mem[idx_of(32'h400) + b]) begin bad++; $display("FAIL bp_data beat%0d: got %h want %h", b, rd_data_q[b], ref_mem[idx_of(32'h400) + b]); end
        total++;
        if (rd_last_q[b] !== (b == 3)) begin bad++; $display("FAIL bp_last beat%0d: got %b want %b", b, rd_last_q[b], b == 3); end
      end
    end
  endtask

  task automatic test_zero_enable();
    wd[0] = 32'h5A5A1234; we[0] = 4'hF; wl[0] = 1;
    do_write(32'h30, 0);
    wd[0] = $urandom(); we[0] = 4'h0; wl[0] = 1;
    do_write(32'h30, 0);
    total++;
    if (wa_missing !== 0 || cmd_acc_after !== 1'b1) begin bad++; $display("FAIL zero_en_handshake: got %b%b want 01", wa_missing, cmd_acc_after); end
    do_read(32'h30, 0, -1, 0);
    total++;
    if (rd_data_q.size() !== 1 || rd_data_q[0] !== 32'h5A5A1234) begin bad++; $display("FAIL zero_en_data: got %h want 5a5a1234", rd_data_q.size() > 0 ? rd_data_q[0] : 32'hx); end
  endtask

  task automatic test_random();
    int start, bs, n_rd;
    logic [31:0] addr;
    logic [W-1:0] e;
    // prefill words 100..131 with a maximum-length burst
    for (int b = 0; b < 32; b++) begin
      wd[b] = $urandom(); we[b] = 4'hF; wl[b] = (b == 31);
    end
    do_write(32'd400, 31);
    total++;
    if (wa_missing !== 0 || cmd_acc_after !== 1'b1) begin bad++; $display("FAIL rand_prefill: got %b%b want 01", wa_missing, cmd_acc_after); end
    n_rd = 0;
    for (int t = 0; t < 24; t++) begin
      start = 100 + $urandom_range(0, 24);
      bs = $urandom_range(0, 7);
      addr = ($urandom_range(0, 15) << 12) + start * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= bs; b++) begin
          wd[b] = $urandom(); we[b] = 4'($urandom_range(0, 15)); wl[b] = (b == bs);
        end
        do_write(addr, bs);
      end else begin
        for (int b = 0; b <= bs; b++) exp_q.push_back(ref_mem[(start + b) % DEPTH]);
        do_read(addr, bs, $urandom_range(0, bs), $urandom_range(0, 3));
        n_rd++;
        total++;
        if (rd_data_q.size() !== bs + 1) begin
          bad++; $display("FAIL rand_count t%0d: got %0d want %0d", t, rd_data_q.size(), bs + 1);
          exp_q.delete();
        end else begin
          for (int b = 0; b <= bs; b++) begin
            e = exp_q.pop_front();
            total++;
            if (rd_data_q[b] !== e) begin bad++; $display("FAIL rand_data t%0d beat%0d: got %h want %h", t, b, rd_data_q[b], e); end
            total++;
            if (rd_last_q[b] !== (b == bs)) begin bad++; $display("FAIL rand_last t%0d beat%0d: got %b want %b", t, b, rd_last_q[b], b == bs); end
          end
        end
      end
    end
    total++;
    if (prot_err !== 1'b0) begin bad++; $display("FAIL rand_no_error: got %b want 0 (reads %0d)", prot_err, n_rd); end
  endtask

  task automatic test_protocol_error();
    total++;
    if (prot_err !== 1'b0) begin bad++; $display("FAIL perr_before: got %b want 0", prot_err); end
    wd[0] = 32'hCAFE0001; we[0] = 4'hF; wl[0] = 1;
    wd[1] = 32'hCAFE0002; we[1] = 4'hF; wl[1] = 1;
    do_write(32'h800, 1);
    total++;
    if (prot_err !== 1'b1) begin bad++; $display("FAIL perr_set: got %b want 1", prot_err); end
    total++;
    if (wa_missing !== 0 || cmd_acc_after !== 1'b1) begin bad++; $display("FAIL perr_idle_after_beat2: got %b%b want 01", wa_missing, cmd_acc_after); end
    wd[0] = 32'h0BADF00D; we[0] = 4'hF; wl[0] = 1;
    do_write(32'h808, 0);
    total++;
    if (wa_missing !== 0 || cmd_acc_after !== 1'b1) begin bad++; $display("FAIL perr_next_cmd: got %b%b want 01", wa_missing, cmd_acc_after); end
    do_read(32'h800, 2, -1, 0);
    total++;
    if (rd_data_q.size() !== 3 || rd_data_q[0] !== 32'hCAFE0001 || rd_data_q[1] !== 32'hCAFE0002 || rd_data_q[2] !== 32'h0BADF00D) begin
      bad++; $display("FAIL perr_data: got %0d beats %h %h want cafe0001 cafe0002 0badf00d", rd_data_q.size(),
                      rd_data_q.size() > 0 ? rd_data_q[0] : 32'hx, rd_data_q.size() > 1 ? rd_data_q[1] : 32'hx);
    end
    total++;
    if (prot_err !== 1'b1) begin bad++; $display("FAIL perr_sticky: got %b want 1", prot_err); end
  endtask

  task automatic test_reset_abort();
    int base;
    int seen;
    base = idx_of(32'hC00);
    for (int b = 0; b < 4; b++) begin
      wd[b] = 32'h7700_0000 + b; we[b] = 4'hF; wl[b] = (b == 3);
    end
    do_write(32'hC00, 3);
    // start a 4-beat write, complete two beats, then reset mid-cycle
    wait_idle();
    cmd_valid = 1; cmd_addr = 32'hC00; cmd_rw = 1; cmd_bs = 5'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int b = 0; b < 2; b++) begin
      w_valid = 1; w_data = 32'h9900_0000 + b; w_en = 4'hF; w_last = 0;
      @(posedge clk);
      model_write(base + b, 32'h9900_0000 + b, 4'hF);
      @(negedge clk);
    end
    w_data = 32'hFFFF_FFFF;
    #2 rst = 1;
    #1;
    total++;
    if ({w_accept, cmd_accept, prot_err} !== 3'b000) begin bad++; $display("FAIL abort_write_outputs: got %b want 000", {w_accept, cmd_accept, prot_err}); end
    @(negedge clk);
    w_valid = 0; w_en = '0;
    rst = 0;
    @(negedge clk);
    total++;
    if (cmd_accept !== 1'b1) begin bad++; $display("FAIL abort_write_idle: got %b want 1", cmd_accept); end
    do_read(32'hC00, 3, -1, 0);
    total++;
    if (rd_data_q.size() !== 4) begin bad++; $display("FAIL abort_read_count: got %0d want 4", rd_data_q.size()); end
    else begin
      for (int b = 0; b < 4; b++) begin
        total++;
        if (rd_data_q[b] !== ref_mem[base + b]) begin bad++; $display("FAIL abort_retained beat%0d: got %h want %h", b, rd_data_q[b], ref_mem[base + b]); end
      end
    end
    // reset during a read beat
    wait_idle();
    cmd_valid = 1; cmd_addr = 32'hC00; cmd_rw = 0; cmd_bs = 5'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    total++;
    if (r_valid !== 1'b1) begin bad++; $display("FAIL abort_read_valid: got %b want 1", r_valid); end
    #2 rst = 1;
    #1;
    total++;
    if ({r_valid, r_last, r_data} !== '0) begin bad++; $display("FAIL abort_read_outputs: got %h want 0", {r_valid, r_last, r_data}); end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin
      r_accept = 1;
      @(negedge clk);
      if (r_valid === 1'b1) seen++;
    end
    r_accept = 0;
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_readvalid: got %0d want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_known[i] = 0;
    end
    test_reset();
    test_single();
    test_byte_enables();
    test_burst_wrap();
    test_backpressure();
    test_zero_enable();
    test_random();
    test_protocol_error();
    test_reset_abort();
    total++;
    if (drv_timeout !== 0) begin bad++; $display("FAIL handshake_timeout: got %b want 0", drv_timeout); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
